// File: rtl/comp_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : comp_rr_arbiter_if
//  Description : Request/operand bus and valid/ready response port between a
//                set of requesters and the shared comparator arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface comp_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_in;
  logic [N_REQ*WIDTH-1:0] b_in;
  logic [N_REQ-1:0]       gnt;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic                   rsp_greater;
  logic                   rsp_equal;
  logic                   rsp_less;

  // Arbiter side
  modport slave (
    input  req, a_in, b_in, rsp_ready,
    output gnt, rsp_valid, rsp_id, rsp_greater, rsp_equal, rsp_less
  );

  // Requester / response-consumer side
  modport master (
    output req, a_in, b_in, rsp_ready,
    input  gnt, rsp_valid, rsp_id, rsp_greater, rsp_equal, rsp_less
  );
endinterface
`default_nettype wire

// File: rtl/comp_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : comp_rr_arbiter
//  Description : Round-robin scheduler sharing one registered unsigned
//                magnitude comparator among N_REQ requesters. Grants one
//                requester, latches its operands, compares, and returns
//                greater/equal/less flags tagged with the requester ID over
//                a valid/ready response port.
//  Revision    : 1.0 - initial release
// ============================================================================
module comp_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  comp_rr_arbiter_if.slave   bus
);

  localparam int c_ptr_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Reject parameter sets where rsp_id cannot name every requester.
  generate
    if ((N_REQ < 2) || (N_REQ > 8) || ((1 << ID_W) < N_REQ)) begin : g_param_check
      $error("comp_rr_arbiter: illegal N_REQ/ID_W combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_ptr_w-1:0] r_rr_ptr;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [N_REQ-1:0]   r_gnt;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic               r_greater;
  logic               r_equal;
  logic               r_less;

  logic               w_found;
  logic [c_ptr_w-1:0] w_winner;
  logic [c_ptr_w-1:0] w_next_ptr;
  logic [N_REQ-1:0]   w_onehot;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;

  // Rotating priority search: first set req bit at or above rr_ptr, wrapping.
  always_comb begin : p_pick
    int idx;
    idx        = 0;
    w_found    = 1'b0;
    w_winner   = '0;
    w_next_ptr = '0;
    w_onehot   = '0;
    w_a        = '0;
    w_b        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % N_REQ;
      if (!w_found && bus.req[idx]) begin
        w_found       = 1'b1;
        w_winner      = c_ptr_w'(idx);
        w_next_ptr    = c_ptr_w'((idx + 1) % N_REQ);
        w_onehot      = '0;
        w_onehot[idx] = 1'b1;
        w_a           = bus.a_in[idx*WIDTH +: WIDTH];
        w_b           = bus.b_in[idx*WIDTH +: WIDTH];
      end
    end
  end

  // Grant / compare / respond sequencer with all outputs registered.
  always_ff @(posedge clk) begin : p_fsm
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_greater   <= 1'b0;
      r_equal     <= 1'b0;
      r_less      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a      <= w_a;
            r_b      <= w_b;
            r_gnt    <= w_onehot;
            r_rsp_id <= ID_W'(w_winner);
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_CMP;
          end else begin
            r_gnt <= '0;
          end
        end
        S_CMP: begin
          // Operands were latched at grant, so late req/operand changes
          // from the requester cannot disturb the result.
          r_greater   <= (r_a > r_b);
          r_equal     <= (r_a == r_b);
          r_less      <= (r_a < r_b);
          r_rsp_valid <= 1'b1;
          r_gnt       <= '0;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_gnt       <= '0;
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_id      = r_rsp_id;
  assign bus.rsp_greater = r_greater;
  assign bus.rsp_equal   = r_equal;
  assign bus.rsp_less    = r_less;

endmodule
`default_nettype wire

// File: tb/tb_comp_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comp_rr_arbiter
//  Description : Self-checking bench for comp_rr_arbiter: behavioural model
//                compared every cycle, directed literal checks, random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comp_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic chk_en;

  comp_rr_arbiter_if #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();

  comp_rr_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------------ model
  int         m_phase;   // 0 waiting for a request, 1 granted, 2 response held
  int         m_ptr;
  logic [3:0] m_gnt;
  logic       m_valid;
  int         m_id;
  logic       m_gt, m_eq, m_lt;
  logic [7:0] m_pa, m_pb;
  int         grant_log[$];

  function automatic int pick(input logic [3:0] r, input int ptr);
    int w;
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && r[(ptr + k) % N]) w = (ptr + k) % N;
    return w;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_ptr <= 0; m_gnt <= '0; m_valid <= 1'b0; m_id <= 0;
      m_gt <= 1'b0; m_eq <= 1'b0; m_lt <= 1'b0; m_pa <= '0; m_pb <= '0;
    end else if (m_phase == 0) begin
      if (bus.req != '0) begin
        m_pa    <= bus.a_in[pick(bus.req, m_ptr)*W +: W];
        m_pb    <= bus.b_in[pick(bus.req, m_ptr)*W +: W];
        m_gnt   <= 4'(1 << pick(bus.req, m_ptr));
        m_id    <= pick(bus.req, m_ptr);
        m_ptr   <= (pick(bus.req, m_ptr) + 1) % N;
        m_phase <= 1;
        grant_log.push_back(pick(bus.req, m_ptr));
      end else begin
        m_gnt <= '0;
      end
    end else if (m_phase == 1) begin
      m_gnt   <= '0;
      m_valid <= 1'b1;
      m_gt    <= (int'(m_pa) > int'(m_pb));
      m_eq    <= (int'(m_pa) == int'(m_pb));
      m_lt    <= (int'(m_pa) < int'(m_pb));
      m_phase <= 2;
    end else if (bus.rsp_ready) begin
      m_valid <= 1'b0;
      m_phase <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, sampled away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt", 32'(bus.gnt), 32'(m_gnt));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
      check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      check("flags", {29'd0, bus.rsp_greater, bus.rsp_equal, bus.rsp_less},
            {29'd0, m_gt, m_eq, m_lt});
      if (bus.rsp_valid)
        check("onehot_flags", 32'(bus.rsp_greater) + 32'(bus.rsp_equal) + 32'(bus.rsp_less), 32'd1);
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input string name, input int exp);
    int got;
    got = -1;
    for (int c = 0; c < 12 && got < 0; c++) begin
      cyc();
      for (int i = 0; i < N; i++) if (bus.gnt[i]) got = i;
    end
    check(name, 32'(got), 32'(exp));
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.a_in[i*W +: W] = a;
    bus.b_in[i*W +: W] = b;
  endtask

  task automatic single(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] exp_flags);
    bus.req = 4'b0001;
    set_ops(0, a, b);
    cyc();
    check({name, "_gnt"}, 32'(bus.gnt), 32'h1);
    bus.req = 4'b0000;
    cyc();
    check({name, "_valid"}, 32'(bus.rsp_valid), 32'h1);
    check({name, "_id"}, 32'(bus.rsp_id), 32'h0);
    check({name, "_flags"}, {29'd0, bus.rsp_greater, bus.rsp_equal, bus.rsp_less},
          32'(exp_flags));
    cyc();
    check({name, "_done"}, 32'(bus.rsp_valid), 32'h0);
  endtask

  initial begin
    int base;
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    rst = 1'b1;
    bus.req = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.rsp_ready = 1'b1;

    // Reset with random requests present
    bus.req = 4'($urandom);
    cyc();
    chk_en = 1'b1;
    bus.req = 4'($urandom);
    cyc();
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_id", 32'(bus.rsp_id), 32'h0);
    rst = 1'b0;
    bus.req = 4'b0110;
    cyc();
    check("first_gnt_lowest", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    cyc();
    cyc();

    // Single compares
    single("gt", 8'hA5, 8'h3C, 3'b100);
    single("eq", 8'h80, 8'h80, 3'b010);
    single("lt", 8'h00, 8'hFF, 3'b001);

    // Round robin from a freshly reset pointer
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    base = grant_log.size();
    bus.req = 4'b1111;
    for (int i = 0; i < N; i++) set_ops(i, 8'(i * 16), 8'(40));
    wait_gnt("rr0", 0);
    wait_gnt("rr1", 1);
    wait_gnt("rr2", 2);
    wait_gnt("rr3", 3);
    wait_gnt("rr4", 0);
    bus.req = '0;
    check("rr_log_len", 32'(grant_log.size() - base), 32'd5);
    if (grant_log.size() - base >= 5)
      check("rr_log_order", {grant_log[base+1][7:0], grant_log[base+2][7:0],
                             grant_log[base+3][7:0], grant_log[base+4][7:0]}, 32'h01020300);
    cyc();
    cyc();

    // Wrap-around: serve 2 so the pointer sits at 3, then 0101
    bus.req = 4'b0100;
    wait_gnt("wrap_pre", 2);
    bus.req = '0;
    cyc();
    cyc();
    bus.req = 4'b0101;
    wait_gnt("wrap_first", 0);
    bus.req = 4'b0100;
    wait_gnt("wrap_second", 2);
    bus.req = '0;
    cyc();
    cyc();

    // Backpressure
    bus.rsp_ready = 1'b0;
    bus.req = 4'b0010;
    set_ops(1, 8'h10, 8'h20);
    wait_gnt("bp_gnt", 1);
    cyc();
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'h1);
      check("bp_hold_less", 32'(bus.rsp_less), 32'h1);
      check("bp_hold_gnt", 32'(bus.gnt), 32'h0);
      if (c < 4) cyc();
    end
    bus.rsp_ready = 1'b1;
    cyc();
    check("bp_release", 32'(bus.rsp_valid), 32'h0);
    check("bp_idle_gnt", 32'(bus.gnt), 32'h0);
    cyc();
    check("bp_next_gnt", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    cyc();
    cyc();

    // Reset while comparing
    bus.req = 4'b0001;
    wait_gnt("abort_cmp_gnt", 0);
    rst = 1'b1;
    bus.req = '0;
    cyc();
    check("abort_cmp_valid", 32'(bus.rsp_valid), 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      check("abort_cmp_quiet", 32'(bus.rsp_valid), 32'h0);
    end

    // Reset while responding
    bus.req = 4'b0001;
    wait_gnt("abort_resp_gnt", 0);
    bus.req = '0;
    cyc();
    check("abort_resp_pre", 32'(bus.rsp_valid), 32'h1);
    rst = 1'b1;
    cyc();
    check("abort_resp_valid", 32'(bus.rsp_valid), 32'h0);
    rst = 1'b0;
    bus.req = 4'b0010;
    wait_gnt("post_rst_gnt", 1);
    bus.req = '0;
    cyc();
    check("post_rst_valid", 32'(bus.rsp_valid), 32'h1);
    check("post_rst_id", 32'(bus.rsp_id), 32'h1);
    cyc();
    cyc();

    // Random traffic under the requester contract
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] g;
      logic [7:0] a;
      g = bus.gnt;
      for (int i = 0; i < N; i++) begin
        a = 8'($urandom);
        if (bus.req[i] && g[i]) begin
          if ($urandom_range(1, 0) == 0) bus.req[i] = 1'b0;
          else set_ops(i, a, ($urandom_range(3, 0) == 0) ? a : 8'($urandom));
        end else if (!bus.req[i] && $urandom_range(9, 0) < 3) begin
          bus.req[i] = 1'b1;
          set_ops(i, a, ($urandom_range(3, 0) == 0) ? a : 8'($urandom));
        end
      end
      bus.rsp_ready = ($urandom_range(9, 0) < 6);
      rst = ($urandom_range(299, 0) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
